seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: Start  input  1  request a multiply; sampled only in IDLE.
REQ-005 Port: Signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with Start.
REQ-006 Port: In1  input  WIDTH  multiplicand; sampled with Start.
REQ-007 Port: In2  input  WIDTH  multiplier; sampled with Start.
REQ-008 Port: Busy  output  1  high while an operation is in progress (CALC or FIX).
REQ-009 Port: Done  output  1  one-cycle pulse marking valid results.
REQ-010 Port: Out  output  WIDTH  low half of the product.
REQ-011 Port: OutHigh  output  WIDTH  high half of the product.
REQ-012 Port: Overflow  output  1  product not representable in WIDTH bits.

Function
REQ-013 The block SHALL use a four-state FSM: IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with Start=1, the block SHALL latch Signed, the operand magnitudes (absolute values if Signed, else raw), the result sign (In1 MSB XOR In2 MSB when Signed, else 0), and clear the 2*WIDTH accumulator and bit counter; next state is CALC.
REQ-015 CALC SHALL perform exactly WIDTH radix-2 shift-add iterations, one per cycle, over unsigned magnitudes, then go to FIX.
REQ-016 FIX SHALL negate the 2*WIDTH accumulator when the result sign is 1, register Out, OutHigh and Overflow, then go to DONE.
REQ-017 DONE SHALL assert Done for exactly one cycle and return to IDLE; Start in DONE SHALL be ignored.
REQ-018 Latency: with Start accepted at edge k, Done SHALL be high in the cycle following edge k+WIDTH+2; Busy SHALL be high from after edge k until after edge k+WIDTH+1.
REQ-019 Start while Busy or Done SHALL be ignored; In1, In2 and Signed may change freely after acceptance without affecting the result.
REQ-020 {OutHigh,Out} SHALL equal the exact 2*WIDTH-bit product (signed or unsigned per the latched Signed); magnitude -2^(WIDTH-1) SHALL be handled without loss.
REQ-021 Overflow SHALL be (OutHigh != WIDTH copies of Out MSB) when Signed, and (OutHigh != 0) when unsigned.
REQ-022 Out, OutHigh and Overflow SHALL hold their values from DONE until the next FIX update.
REQ-023 Zero operands SHALL take full latency (no early exit).

Reset
REQ-024 rst=1 SHALL asynchronously force IDLE and set Busy=0, Done=0, Out=0, OutHigh=0 and Overflow=0, and clear all internal registers.
REQ-025 Reset during CALC or FIX SHALL abort the operation with no Done pulse; a Start accepted after release SHALL operate normally.

Structure
REQ-026 Package mul_pkg SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-027 A combinational sub-module mul_negate (conditional two's complement, width parameter) SHALL be used for both operand magnitude conversion and result sign fix.

Verification (WIDTH=32)
REQ-028 Signed, 7 * -3 -> Done at k+34; Out=0xFFFFFFEB, OutHigh=0xFFFFFFFF, Overflow=0.
REQ-029 Signed, 0x80000000 * 0xFFFFFFFF -> Out=0x80000000, OutHigh=0x00000000, Overflow=1.
REQ-030 Unsigned, 0xFFFFFFFF * 0xFFFFFFFF -> OutHigh=0xFFFFFFFE, Out=0x00000001, Overflow=1; unsigned 0x10000 * 0x10000 -> OutHigh=1, Out=0, Overflow=1.
REQ-031 Start pulsed again at k+5 with different operands -> ignored; result matches the first operands; exactly one Done.
REQ-032 rst asserted at k+10 mid-CALC -> outputs 0 immediately, no Done; next Start 5*6 unsigned -> Out=30, Overflow=0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and defaults for the sequential multiplier.
package mul_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_negate.sv
// Conditional two's complement: y = en ? -a : a.
module mul_negate #(
    parameter int unsigned W = 32
) (
    input  logic         en,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    always_comb begin
        y = en ? (~a + W'(1)) : a;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, one iteration per cycle, signed or unsigned.
// Signed operands are reduced to magnitudes; the sign is reapplied in FIX.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] OutHigh,
    output logic             Overflow
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t            state;
    state_t            state_nx;

    logic              sgn;
    logic              neg;
    logic [WIDTH-1:0]  mp;
    logic [DW-1:0]     mc;
    logic [DW-1:0]     acc;
    logic [CW-1:0]     cnt;

    logic [WIDTH-1:0]  mag1;
    logic [WIDTH-1:0]  mag2;
    logic [DW-1:0]     fixed;
    logic              ovf;
    logic              calc_end;

    mul_negate #(.W(WIDTH)) u_neg_in1 (
        .en (Signed & In1[WIDTH-1]),
        .a  (In1),
        .y  (mag1)
    );

    mul_negate #(.W(WIDTH)) u_neg_in2 (
        .en (Signed & In2[WIDTH-1]),
        .a  (In2),
        .y  (mag2)
    );

    mul_negate #(.W(DW)) u_neg_res (
        .en (neg),
        .a  (acc),
        .y  (fixed)
    );

    // CALC spends one extra cycle at cnt==WIDTH to hand off to FIX
    assign calc_end = (cnt == CW'(WIDTH));

    always_comb begin
        if (sgn) begin
            ovf = (fixed[DW-1:WIDTH] != {WIDTH{fixed[WIDTH-1]}});
        end else begin
            ovf = (fixed[DW-1:WIDTH] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (Start)    state_nx = CALC;
            CALC: if (calc_end) state_nx = FIX;
            FIX:                state_nx = DONE;
            DONE:               state_nx = IDLE;
            default:            state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == CALC) || (state == FIX);
        Done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn      <= 1'b0;
            neg      <= 1'b0;
            mp       <= '0;
            mc       <= '0;
            acc      <= '0;
            cnt      <= '0;
            Out      <= '0;
            OutHigh  <= '0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        sgn <= Signed;
                        neg <= Signed & (In1[WIDTH-1] ^ In2[WIDTH-1]);
                        mc  <= DW'(mag1);
                        mp  <= mag2;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    if (!calc_end) begin
                        if (mp[0]) begin
                            acc <= acc + mc;
                        end
                        mc  <= mc << 1;
                        mp  <= mp >> 1;
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    Out      <= fixed[WIDTH-1:0];
                    OutHigh  <= fixed[DW-1:WIDTH];
                    Overflow <= ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed bench for seq_multiplier against a 64-bit arithmetic model.
module tb_seq_multiplier;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = W + 2;

    logic          clk;
    logic          rst;
    logic          Start;
    logic          Signed;
    logic [W-1:0]  In1;
    logic [W-1:0]  In2;
    logic          Busy;
    logic          Done;
    logic [W-1:0]  Out;
    logic [W-1:0]  OutHigh;
    logic          Overflow;

    int total = 0;
    int bad   = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .Signed   (Signed),
        .In1      (In1),
        .In2      (In2),
        .Busy     (Busy),
        .Done     (Done),
        .Out      (Out),
        .OutHigh  (OutHigh),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] p, output logic ov);
        longint          sp;
        longint unsigned up;
        if (s) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            p  = sp;
            ov = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end else begin
            up = 64'(a) * 64'(b);
            p  = up;
            ov = (up > 64'hFFFF_FFFF);
        end
    endfunction

    // Issue one multiply; optionally re-pulse Start at k+5 and poke Start during DONE.
    task automatic do_mul(input bit s, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [63:0] p;
        logic        ov;
        int          n;
        int          busy_n;
        model(s, a, b, p, ov);
        @(negedge clk);
        Start = 1'b1; Signed = s; In1 = a; In2 = b;
        @(posedge clk); #1;
        Start = 1'b0; Signed = ~s; In1 = $urandom; In2 = $urandom;
        n = 0; busy_n = 0;
        while (!Done && n < 200) begin
            if (Busy) busy_n++;
            if (poke && n == 4) begin
                Start = 1'b1; In1 = $urandom; In2 = $urandom;
            end
            @(posedge clk); #1;
            Start = 1'b0;
            n++;
        end
        chk("latency", 64'(n), 64'(LAT));
        chk("busy_cycles", 64'(busy_n), 64'(LAT));
        chk("busy_in_done", 64'(Busy), 64'd0);
        chk("product", {OutHigh, Out}, p);
        chk("overflow", 64'(Overflow), 64'(ov));
        Start = 1'b1; In1 = $urandom; In2 = $urandom;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("done_pulse", 64'(Done), 64'd0);
        chk("start_in_done_ignored", 64'(Busy), 64'd0);
        chk("hold_product", {OutHigh, Out}, p);
        chk("hold_overflow", 64'(Overflow), 64'(ov));
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        bit          s;
        int          n;
        int          dones;

        rst = 1'b1; Start = 1'b0; Signed = 1'b0; In1 = '0; In2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_out", {OutHigh, Out}, 64'd0);
        chk("rst_ovf", 64'(Overflow), 64'd0);
        @(negedge clk); rst = 1'b0;

        do_mul(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0);
        do_mul(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_mul(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        do_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_mul(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        do_mul(1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        do_mul(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
        do_mul(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_mul(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
        do_mul(1'b0, 32'd12345, 32'd678, 1'b1);

        // Start ignored while busy; check for a single Done afterwards.
        do_mul(1'b1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (Done) dones++;
        end
        chk("no_extra_done", 64'(dones), 64'd0);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: a = $urandom_range(0, 15);
                default: ;
            endcase
            do_mul(s, a, b, i % 7 == 3);
        end

        // Reset mid-CALC aborts without a Done pulse.
        @(negedge clk);
        Start = 1'b1; Signed = 1'b0; In1 = 32'hDEAD_BEEF; In2 = 32'h0000_1234;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_done", 64'(Done), 64'd0);
        chk("abort_out", {OutHigh, Out}, 64'd0);
        chk("abort_ovf", 64'(Overflow), 64'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (Done) dones++;
            if (Busy) n++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        chk("abort_idle", 64'(n), 64'd0);
        do_mul(1'b0, 32'd5, 32'd6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
